// File: rtl/axi_v4_rd_slave.sv
// rtl/axi_v4_rd_slave.sv - AXI4 read-channel responder over a 1-cycle-latency memory port
//
// Purpose: accepts one AR request at a time, walks FIXED/INCR/WRAP bursts over a
// synchronous-read memory port and returns R beats through a 2-entry output FIFO
// with full rready backpressure.
// Optional build macro: AXI_RD_SLV_ERR_CHK_EN (AR legality checks -> SLVERR bursts).
//
// Ports:
//   clk_i, rst_n_i               clock, synchronous active-low reset
//   arvalid_i/arready_o          AR handshake
//   arid_i, araddr_i, arlen_i,   AR payload (arcache/arprot/arlock accepted, ignored)
//   arburst_i, arsize_i
//   rvalid_o/rready_i            R handshake
//   rid_o, rdata_o, rlast_o,     R payload
//   rresp_o
//   mem_rd_en_o, mem_rd_addr_o   memory read strobe and byte address
//   mem_rd_data_i                read data, valid one cycle after mem_rd_en_o
module axi_v4_rd_slave #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [7:0]            arlen_i,
  input  logic [1:0]            arburst_i,
  input  logic [2:0]            arsize_i,
  input  logic [3:0]            arcache_i,
  input  logic [2:0]            arprot_i,
  input  logic                  arlock_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rlast_o,
  output logic [1:0]            rresp_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // One read may be in flight between mem_rd_en and the data arriving.
  logic                  infl_q, infl_last_q, infl_err_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  fifo_err_q  [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  issue, pop, pop_fifo, push, fifo_empty;
  logic                  head_valid, head_last, head_err;
  logic [DATA_WIDTH-1:0] head_data, infl_data;
  logic                  err_chk;

  logic [ADDR_WIDTH-1:0] step, wrap_mask, next_addr;

  logic unused_ar_attrs;
  assign unused_ar_attrs = ^{arcache_i, arprot_i, arlock_i};

  // Address of the beat after addr_q.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) * step - ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: next_addr = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
    endcase
  end

`ifdef AXI_RD_SLV_ERR_CHK_EN
  logic [31:0] chk_step, chk_span;
  always_comb begin
    chk_step = 32'd1 << arsize_i;
    // Bytes from the step-aligned start within its 4KB page to the burst end.
    chk_span = 32'(araddr_i[11:0] & ~(chk_step[11:0] - 12'd1))
             + (32'(arlen_i) + 32'd1) * chk_step;
    err_chk  = (chk_step > 32'(DATA_WIDTH / 8))
            || (arburst_i == 2'b11)
            || ((arburst_i == 2'b10) && !((arlen_i == 8'd1) || (arlen_i == 8'd3) ||
                                          (arlen_i == 8'd7) || (arlen_i == 8'd15)))
            || ((arburst_i == 2'b01) && (chk_span > 32'd4096));
  end
`else
  assign err_chk = 1'b0;
`endif

  // Head of the response stream: FIFO head if any, otherwise the in-flight
  // read is forwarded straight from memory so rvalid follows mem_rd_en by one cycle.
  always_comb begin
    fifo_empty = (fifo_cnt_q == 2'd0);
    infl_data  = infl_err_q ? '0 : mem_rd_data_i;
    head_valid = !fifo_empty || infl_q;
    head_data  = infl_data;
    head_last  = infl_last_q;
    head_err   = infl_err_q;
    if (!fifo_empty) begin
      head_data = fifo_data_q[rd_ptr_q];
      head_last = fifo_last_q[rd_ptr_q];
      head_err  = fifo_err_q[rd_ptr_q];
    end
    pop        = head_valid && rready_i;
    pop_fifo   = pop && !fifo_empty;
    push       = infl_q && !(fifo_empty && pop);
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop_fifo};
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arvalid_i && arready_q) begin
          id_d    = arid_i;
          addr_d  = araddr_i;
          len_d   = arlen_i;
          burst_d = arburst_i;
          size_d  = arsize_i;
          cnt_d   = arlen_i;
          done_d  = 1'b0;
          err_d   = err_chk;
          state_d = BURST;
        end
      end
      BURST: begin
        // Occupancy plus in-flight bounded to 2 so a stalled R channel never overflows.
        issue = !done_q && ((fifo_cnt_q + {1'b0, infl_q}) < 2'd2);
        if (issue) begin
          addr_d = next_addr;
          if (cnt_q == 8'd0) done_d = 1'b1;
          else               cnt_d  = cnt_q - 8'd1;
        end
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_err_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      arready_q   <= (state_d == IDLE);
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      infl_q      <= issue;
      infl_last_q <= issue && (cnt_q == 8'd0);
      infl_err_q  <= err_q;
      fifo_cnt_q  <= fifo_cnt_d;
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (pop_fifo) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= infl_data;
      fifo_last_q[wr_ptr_q] <= infl_last_q;
      fifo_err_q[wr_ptr_q]  <= infl_err_q;
    end
  end

  assign arready_o     = arready_q;
  assign rvalid_o      = head_valid;
  assign rid_o         = id_q;
  assign rdata_o       = head_valid ? head_data : '0;
  assign rlast_o       = head_valid && head_last;
  assign rresp_o       = (head_valid && head_err) ? 2'b10 : 2'b00;
  assign mem_rd_en_o   = issue && !err_q;
  assign mem_rd_addr_o = addr_q;

endmodule

// File: tb/tb_axi_v4_rd_slave.sv
// tb/tb_axi_v4_rd_slave.sv - self-checking bench for axi_v4_rd_slave
module tb_axi_v4_rd_slave;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arvalid, arready;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [1:0]    arburst;
  logic [2:0]    arsize;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arlock;
  logic          rvalid, rready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic [1:0]    rresp;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_v4_rd_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .arvalid_i(arvalid), .arready_o(arready), .arid_i(arid), .araddr_i(araddr),
    .arlen_i(arlen), .arburst_i(arburst), .arsize_i(arsize),
    .arcache_i(arcache), .arprot_i(arprot), .arlock_i(arlock),
    .rvalid_o(rvalid), .rready_i(rready), .rid_o(rid), .rdata_o(rdata),
    .rlast_o(rlast), .rresp_o(rresp),
    .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data)
  );

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a * 32'd3, a + 32'h1234};
  endfunction

  // Memory: data for the strobed address one cycle later, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);
    else           mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  // Address of beat i, from the burst definition (container modulo for WRAP).
  function automatic logic [31:0] exp_addr(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst, input logic [2:0] size,
                                           input int i);
    longint a, step, cont, base, r;
    a    = longint'(addr);
    step = longint'(1) << size;
    if (burst == 2'b00) r = a;
    else if (burst == 2'b10) begin
      cont = (longint'(len) + 1) * step;
      base = a - (a % cont);
      r    = base + ((a - base + longint'(i) * step) % cont);
    end else if (i == 0) r = a;
    else r = a - (a % step) + longint'(i) * step;
    return r[31:0];
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [7:0] len,
                                   input logic [1:0] burst, input logic [2:0] size);
    bit e;
    longint step, first, last;
    e     = 1'b0;
    step  = longint'(1) << size;
    first = longint'(addr) - (longint'(addr) % step);
    last  = first + (longint'(len) + 1) * step - 1;
`ifdef AXI_RD_SLV_ERR_CHK_EN
    if (step > DW / 8) e = 1'b1;
    if (burst == 2'b11) e = 1'b1;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
    if (burst == 2'b01 && ((first >> 12) != (last >> 12))) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge. mode 0: rready high, 1: 1,0,0,1 pattern, 2: random.
  task automatic run_burst(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int mode,
                           input bit timing);
    int  n, issued, accepted, k, done_k, first_rv, first_en, max_ahead, ar_bad, unstable;
    bit  perr, prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    int  rr_pat [4];
    rr_pat = '{1, 0, 0, 1};
    n = int'(len) + 1;
    issued = 0; accepted = 0; k = 1; done_k = -1; first_rv = -1; first_en = -1;
    max_ahead = 0; ar_bad = 0; unstable = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    perr = model_err(addr, len, burst, size);

    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size;
    chk("arready_idle", arready, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; araddr = $urandom; arlen = 8'($urandom); arid = IW'($urandom);
    while (done_k < 0 && k < 200 + 4 * n) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = rr_pat[(k - 1) % 4] != 0;
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (mem_rd_en) begin
        if (issued < n)
          chk($sformatf("rd_addr_%0d", issued), mem_rd_addr, exp_addr(addr, len, burst, size, issued));
        if (first_en < 0) first_en = k;
        issued++;
      end
      if (issued - accepted > max_ahead) max_ahead = issued - accepted;
      if (arready !== 1'b0) ar_bad++;
      if (prev_stall && (rvalid !== 1'b1 || rdata !== prev_data || rlast !== prev_last)) unstable++;
      if (rvalid && first_rv < 0) first_rv = k;
      if (rvalid && rready) begin
        chk($sformatf("rdata_%0d", accepted), rdata,
            perr ? '0 : pat(exp_addr(addr, len, burst, size, accepted)));
        chk($sformatf("rlast_%0d", accepted), rlast, accepted == n - 1);
        chk($sformatf("rid_%0d", accepted), rid, id);
        chk($sformatf("rresp_%0d", accepted), rresp, perr ? 2'b10 : 2'b00);
        accepted++;
        if (rlast) done_k = k;
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_last  = rlast;
      @(negedge clk);
      k++;
    end
    chk("burst_done", done_k >= 0, 1);
    chk("beat_count", accepted, n);
    chk("mem_rd_count", issued, perr ? 0 : n);
    chk("reads_ahead_le2", max_ahead <= 2, 1);
    chk("arready_low_in_burst", ar_bad, 0);
    chk("rdata_stable_stall", unstable, 0);
    chk("arready_after_last", arready, 1);
    if (timing) begin
      if (!perr) chk("lat_mem_rd_en", first_en, 1);
      chk("lat_rvalid", first_rv, 2);
      chk("lat_last", done_k, n + 1);
    end
  endtask

  initial begin
    int got, k;
    logic [1:0] b;
    logic [7:0] l;
    rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0; arid = '0; araddr = '0; arlen = '0;
    arburst = '0; arsize = '0; arcache = 4'hF; arprot = 3'h7; arlock = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    rst_n = 1'b1;
    chk("release_arready", arready, 0);
    @(negedge clk);

    run_burst(4'hA, 32'h100, 8'd3, 2'b01, 3'd4, 0, 1'b1);
    run_burst(4'h3, 32'h1030, 8'd3, 2'b10, 3'd4, 0, 1'b1);
    run_burst(4'h5, 32'h40, 8'd2, 2'b00, 3'd4, 0, 1'b1);
    run_burst(4'h6, 32'h40, 8'd0, 2'b00, 3'd4, 0, 1'b1);
    run_burst(4'h7, 32'h800, 8'd7, 2'b01, 3'd4, 1, 1'b0);
    run_burst(4'h8, 32'hFFFF_FFE8, 8'd3, 2'b01, 3'd4, 0, 1'b1);
    run_burst(4'h9, 32'h200, 8'd1, 2'b01, 3'd5, 0, 1'b1);
    run_burst(4'h2, 32'hFF0, 8'd1, 2'b01, 3'd4, 0, 1'b1);
    run_burst(4'h1, 32'h300, 8'd2, 2'b11, 3'd2, 1, 1'b0);

    // Reset in the middle of an 8-beat burst.
    arvalid = 1'b1; arid = 4'hC; araddr = 32'h2000; arlen = 8'd7; arburst = 2'b01; arsize = 3'd4;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    got = 0; k = 0;
    while (got < 2 && k < 20) begin
      if (rvalid && rready) got++;
      @(negedge clk);
      k++;
    end
    chk("pre_reset_beats", got, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_mem_rd_en", mem_rd_en, 0);
    chk("midrst_arready", arready, 0);
    chk("midrst_rlast", rlast, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_arready", arready, 1);
    run_burst(4'hD, 32'h3000, 8'd7, 2'b01, 3'd4, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      b = 2'($urandom_range(0, 3));
      l = (b == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      run_burst(IW'($urandom), $urandom, l, b, 3'($urandom_range(0, 4)),
                $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_v4_rd_slave.md
Name: axi_v4_rd_slave

Overview:
- AXI4 read-channel responder (slave end of the team's AXI4 read interface).
- Accepts AR requests and walks FIXED/INCR/WRAP bursts over a simple synchronous-read memory port with 1-cycle read latency.
- Returns R beats with full rready backpressure support.
- Sits in front of on-chip SRAM/register banks that the prep-stage masters read over AXI4.

Parameters:
- DATA_WIDTH, 128, rdata and mem_rd_data width in bits; power of 2, 8..1024.
- ADDR_WIDTH, 32, byte address width of araddr and mem_rd_addr.
- ID_WIDTH, 4, arid/rid width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- arvalid/arready  in/out  1  AR handshake.
- arid  in  ID_WIDTH  transaction ID.
- araddr  in  ADDR_WIDTH  start byte address.
- arlen  in  8  beats minus 1.
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- arsize  in  3  log2 bytes per beat.
- arcache/arprot/arlock  in  4/3/1  accepted and ignored.
- rvalid/rready  out/in  1  R handshake.
- rid  out  ID_WIDTH  echo of captured arid.
- rdata  out  DATA_WIDTH  beat data.
- rlast  out  1  final beat of burst.
- rresp  out  2  00 OKAY, 10 SLVERR.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  byte address of the beat.
- mem_rd_data  in  DATA_WIDTH  valid exactly 1 cycle after mem_rd_en.

Behaviour:
- Reset (rst_n=0 at clk edge) values: arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_rd_en=0, mem_rd_addr=0, state=IDLE, output FIFO emptied, in-flight read discarded.
  - Reset mid-burst aborts the burst without completing outstanding beats.
  - arready is asserted the first cycle after reset deasserts.
- State IDLE:
  - arready=1.
  - On arvalid&arready, capture id/addr/len/burst/size, set beat counter=arlen, go to BURST.
  - No combinational path from arvalid to arready.
- State BURST:
  - arready=0.
  - Issue mem_rd_en with mem_rd_addr = current beat address whenever (FIFO occupancy + in-flight) < 2.
  - Decrement the beat counter per issued read.
  - After issuing the last read, return to IDLE once the FIFO has drained and the last beat has been accepted (rlast&rvalid&rready). arready rises the cycle after that.
- Output FIFO:
  - 2 entries; writes mem_rd_data the cycle after mem_rd_en.
  - rvalid = FIFO non-empty; rdata/rlast/rresp come from the FIFO head.
  - Entry pops on rvalid&rready. Simultaneous push and pop is allowed.
  - rvalid, once asserted, holds with stable rdata/rid/rlast/rresp until rready.
- Latency and throughput:
  - AR handshake at cycle N -> mem_rd_en at N+1 -> rvalid at N+2.
  - With rready held high: 1 beat/cycle sustained; burst of L beats ends at N+1+L.
- Address arithmetic (per issued beat):
  - step = 1<<arsize.
  - FIXED: address constant.
  - INCR: addr += step, aligned to step after the first beat.
  - WRAP: container = (arlen+1)*step, base = addr & ~(container-1), next = base | ((addr+step) & (container-1)).
  - Reserved burst 11 is treated as INCR.
  - Arithmetic is modulo 2^ADDR_WIDTH; a carry out of the top bit is dropped.
- rlast is asserted on the beat with counter==0; arlen=0 gives a single beat with rlast=1.
- rresp=00 on every beat unless the optional feature is enabled.
- One outstanding transaction at a time; no reordering; rid constant for the burst.

Optional Feature:
- Macro: AXI_RD_SLV_ERR_CHK_EN.
- Enabled: at AR capture, flag an error if any of the following holds:
  - (1<<arsize) > DATA_WIDTH/8;
  - arburst==11;
  - WRAP with arlen not in {1,3,7,15};
  - INCR crossing a 4KB boundary.
  - Errored bursts still return arlen+1 beats with correct rlast, rresp=10 and rdata=0, with mem_rd_en held 0 for the whole burst.
- Disabled: no checks; all beats read memory and rresp=00.

Test Plan:
- INCR araddr=0x100, arlen=3, arsize=4, rready=1 -> mem_rd_addr 0x100/0x110/0x120/0x130; rvalid at N+2..N+5; rlast only on beat 3; rid=arid.
- WRAP araddr=0x1030, arlen=3, arsize=4 -> addresses 0x1030, 0x1000, 0x1010, 0x1020.
- FIXED araddr=0x40, arlen=2 -> three reads at 0x40. arlen=0 -> one beat with rlast=1.
- INCR arlen=7 with rready toggling 1,0,0,1 -> no beat lost or duplicated; rdata stable while stalled; at most 2 reads ahead of acceptance; arready=0 until the cycle after rlast is accepted.
- rst_n=0 at beat 2 of an 8-beat burst -> next cycle rvalid=0, mem_rd_en=0; arready=1 the cycle after release; a new burst completes correctly.
- With AXI_RD_SLV_ERR_CHK_EN: arsize=5 at DATA_WIDTH=128, arlen=1 -> 2 beats, rresp=10, rdata=0, no mem_rd_en. INCR 0xFF0, arlen=1, arsize=4 -> SLVERR.
